// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and stall controller for the five-stage core.
//
// Produces the per-stage hold/flush controls for the IF/ID, ID/EX and EX/MEM
// pipeline registers and the PC redirect for taken branches and jumps.
// Every output is combinational from the registered state plus the inputs of
// the current cycle, so a hazard is answered in the cycle it appears.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rs1_raddr/rs2_raddr      ID-stage source register addresses
//   rs1_re/rs2_re            ID-stage source read enables
//   rd_waddr_ex, wb_sel_ex   destination / write-back select held in ID/EX
//   br_taken, br_target      EX branch resolution and redirect address
//   mem_req, mem_ready       MEM-stage bus handshake
//   hold_pc/if/id/ex         freeze PC, IF-ID, ID-EX, EX-MEM registers
//   flush_if, flush_id       load NOP into IF-ID / ID-EX
//   pc_redirect, redirect_addr   load redirect_addr into the PC
//   bus_err                  one-cycle memory timeout pulse
//   stall_cnt                saturating count of cycles with hold_pc=1
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,      // 1..15
    parameter int unsigned MEM_TIMEOUT  = 255,    // 1..65535
    parameter logic [2:0]  WB_MEM       = 3'd1    // write-back select of a load
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_raddr,
    input  logic [4:0]  rs2_raddr,
    input  logic        rs1_re,
    input  logic        rs2_re,
    input  logic [4:0]  rd_waddr_ex,
    input  logic [2:0]  wb_sel_ex,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        hold_pc,
    output logic        hold_if,
    output logic        hold_id,
    output logic        hold_ex,
    output logic        flush_if,
    output logic        flush_id,
    output logic        pc_redirect,
    output logic [31:0] redirect_addr,
    output logic        bus_err,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

    localparam logic [3:0]  FLUSH_LOAD   = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state_reg, state_next;
    state_t      eff_state;
    logic [3:0]  flush_cnt_reg, flush_cnt_next;
    logic [15:0] wait_cnt_reg, wait_cnt_next;
    logic [31:0] stall_cnt_reg;
    logic        first_reg;        // first cycle after reset release
    logic        bus_err_prev_reg; // bus_err was high last cycle
    logic        quiet;
    logic        ms;
    logic        lu;
    logic        timeout;

    // Load-use detection: one comparator per ID-stage source port.
    logic [4:0] src_addr [2];
    logic [1:0] src_re;
    logic [1:0] src_hit;

    assign src_addr[0] = rs1_raddr;
    assign src_addr[1] = rs2_raddr;
    assign src_re      = {rs2_re, rs1_re};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_re[gi] & (src_addr[gi] == rd_waddr_ex);
        end
    endgenerate

    assign lu = (wb_sel_ex == WB_MEM) & (rd_waddr_ex != 5'd0) & (|src_hit);
    assign ms = mem_req & ~mem_ready;

    // Outputs stay silent during reset and for the cycle after it.
    assign quiet = rst | first_reg;

    // The previous-cycle guard keeps bus_err from ever lasting two cycles,
    // which otherwise happens when MEM_TIMEOUT is 1.
    assign timeout = ms & (wait_cnt_reg >= TIMEOUT_LAST) & ~bus_err_prev_reg;

    always_comb begin
        hold_pc        = 1'b0;
        hold_if        = 1'b0;
        hold_id        = 1'b0;
        hold_ex        = 1'b0;
        flush_if       = 1'b0;
        flush_id       = 1'b0;
        pc_redirect    = 1'b0;
        bus_err        = 1'b0;
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        wait_cnt_next  = wait_cnt_reg;

        // Leaving MEM_WAIT resumes whichever sequence the stall interrupted.
        eff_state = state_reg;
        if (state_reg == MEM_WAIT) begin
            eff_state = (flush_cnt_reg != 4'd0) ? FLUSH : RUN;
        end

        if (!quiet) begin
            if (timeout) begin
                bus_err       = 1'b1;
                wait_cnt_next = 16'd0;
                state_next    = (flush_cnt_reg != 4'd0) ? FLUSH : RUN;
            end else if (ms) begin
                // Whole pipe frozen; the pending flush count waits with it.
                hold_pc       = 1'b1;
                hold_if       = 1'b1;
                hold_id       = 1'b1;
                hold_ex       = 1'b1;
                state_next    = MEM_WAIT;
                wait_cnt_next = wait_cnt_reg + 16'd1;
            end else begin
                wait_cnt_next = 16'd0;
                if (eff_state == FLUSH) begin
                    // Wrong-path fetches still draining; no branch can
                    // resolve here and load-use is moot for flushed slots.
                    flush_if       = 1'b1;
                    flush_cnt_next = flush_cnt_reg - 4'd1;
                    state_next     = (flush_cnt_reg == 4'd1) ? RUN : FLUSH;
                end else begin
                    state_next = RUN;
                    if (br_taken) begin
                        pc_redirect    = 1'b1;
                        flush_if       = 1'b1;
                        flush_id       = 1'b1;
                        flush_cnt_next = FLUSH_LOAD;
                        state_next     = (FLUSH_LOAD != 4'd0) ? FLUSH : RUN;
                    end else if (lu) begin
                        // One bubble into EX while the load reaches MEM.
                        hold_pc  = 1'b1;
                        hold_if  = 1'b1;
                        flush_id = 1'b1;
                    end
                end
            end
        end
    end

    assign redirect_addr = pc_redirect ? br_target : 32'd0;
    assign stall_cnt     = quiet ? 32'd0 : stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= RUN;
            flush_cnt_reg    <= 4'd0;
            wait_cnt_reg     <= 16'd0;
            stall_cnt_reg    <= 32'd0;
            first_reg        <= 1'b1;
            bus_err_prev_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            flush_cnt_reg    <= flush_cnt_next;
            wait_cnt_reg     <= wait_cnt_next;
            first_reg        <= 1'b0;
            bus_err_prev_reg <= bus_err;
            if (hold_pc && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl.
// Each stimulus cycle pushes the reference model's expected outputs into a
// queue; a monitor on the falling edge pops and compares against the DUT.
module tb_pipe_ctrl;

    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned MEM_TIMEOUT  = 4;
    localparam logic [2:0]  WB_MEM       = 3'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1_raddr = '0, rs2_raddr = '0, rd_waddr_ex = '0;
    logic        rs1_re = 1'b0, rs2_re = 1'b0;
    logic [2:0]  wb_sel_ex = '0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        mem_req = 1'b0, mem_ready = 1'b0;
    logic        hold_pc, hold_if, hold_id, hold_ex;
    logic        flush_if, flush_id, pc_redirect, bus_err;
    logic [31:0] redirect_addr, stall_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .WB_MEM      (WB_MEM)
    ) dut (
        .clk(clk), .rst(rst),
        .rs1_raddr(rs1_raddr), .rs2_raddr(rs2_raddr),
        .rs1_re(rs1_re), .rs2_re(rs2_re),
        .rd_waddr_ex(rd_waddr_ex), .wb_sel_ex(wb_sel_ex),
        .br_taken(br_taken), .br_target(br_target),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .hold_pc(hold_pc), .hold_if(hold_if), .hold_id(hold_id), .hold_ex(hold_ex),
        .flush_if(flush_if), .flush_id(flush_id),
        .pc_redirect(pc_redirect), .redirect_addr(redirect_addr),
        .bus_err(bus_err), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [71:0] v;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model state, in terms of the observable behaviour:
    // owed    - flush_if cycles still owed to an earlier redirect
    // stalled - consecutive memory-stall cycles since the last timeout
    int      owed     = 0;
    int      stalled  = 0;
    bit      err_prev = 1'b0;
    bit      rst_prev = 1'b1;
    longint  stalls   = 0;

    function automatic logic [71:0] pack(input logic hp, hi, hd, he, fi, fd, pr, be,
                                         input logic [31:0] ra, sc);
        return {hp, hi, hd, he, fi, fd, pr, be, ra, sc};
    endfunction

    task automatic cyc(input string tag, input bit r,
                       input logic [4:0] a1, input bit re1,
                       input logic [4:0] a2, input bit re2,
                       input logic [4:0] rd, input logic [2:0] wb,
                       input bit br, input logic [31:0] tgt,
                       input bit mreq, input bit mrdy);
        bit hp, hi, hd, he, fi, fd, pr, be;
        logic [31:0] ra;
        logic [31:0] sc;
        bit ms, lu;
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; rs1_raddr = a1; rs1_re = re1; rs2_raddr = a2; rs2_re = re2;
        rd_waddr_ex = rd; wb_sel_ex = wb; br_taken = br; br_target = tgt;
        mem_req = mreq; mem_ready = mrdy;

        {hp, hi, hd, he, fi, fd, pr, be} = '0;
        ra = 32'd0;
        ms = mreq && !mrdy;
        lu = (wb == WB_MEM) && (rd != 0) && ((re1 && a1 == rd) || (re2 && a2 == rd));
        sc = (stalls > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(stalls);

        if (r || rst_prev) begin
            sc = 32'd0;
            owed = 0; stalled = 0; stalls = 0; err_prev = 1'b0;
        end else begin
            assert (!(br && !ms && owed > 0))
                else $error("branch driven while flushing");
            if (ms && stalled >= int'(MEM_TIMEOUT) - 1 && !err_prev) begin
                be = 1'b1;
                stalled = 0;
            end else if (ms) begin
                {hp, hi, hd, he} = 4'b1111;
                stalled++;
                stalls++;
            end else begin
                stalled = 0;
                if (owed > 0) begin
                    fi = 1'b1;
                    owed--;
                end else if (br) begin
                    pr = 1'b1; fi = 1'b1; fd = 1'b1; ra = tgt;
                    owed = int'(FLUSH_CYCLES) - 1;
                end else if (lu) begin
                    hp = 1'b1; hi = 1'b1; fd = 1'b1;
                    stalls++;
                end
            end
            err_prev = be;
        end
        rst_prev = r;
        e.v   = pack(hp, hi, hd, he, fi, fd, pr, be, ra, sc);
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 5'd0, 0, 5'd0, 0, 5'd0, 3'd0, 0, 32'd0, 0, 0);
    endtask

    task automatic mstall(input string tag);
        cyc(tag, 0, 5'd0, 0, 5'd0, 0, 5'd0, 3'd0, 0, 32'd0, 1, 0);
    endtask

    // Monitor: the DUT presents a full output set every cycle.
    initial begin
        exp_t e;
        logic [71:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                act = pack(hold_pc, hold_if, hold_id, hold_ex, flush_if, flush_id,
                           pc_redirect, bus_err, redirect_addr, stall_cnt);
                checks++;
                if (act !== e.v) begin
                    errors++;
                    $display("FAIL txn %0d %s act=%h exp=%h", txn, e.tag, act, e.v);
                end else begin
                    $display("txn %0d %s ok %h", txn, e.tag, act);
                end
                txn++;
            end
        end
    end

    initial begin
        int burst;
        bit r, br, mreq, mrdy;
        logic [2:0] wb;
        burst = 0;

        cyc("reset0", 1, 5'd5, 1, 5'd0, 0, 5'd5, WB_MEM, 1, 32'h44, 0, 0);
        cyc("reset1", 1, 5'd5, 1, 5'd0, 0, 5'd5, WB_MEM, 0, 32'd0, 1, 0);
        cyc("post_reset_quiet", 0, 5'd5, 1, 5'd0, 0, 5'd5, WB_MEM, 0, 32'd0, 0, 0);
        idle("idle");
        // Load-use and its non-hazard variants.
        cyc("lu_rs1", 0, 5'd5, 1, 5'd1, 1, 5'd5, WB_MEM, 0, 32'd0, 0, 0);
        idle("after_lu");
        cyc("lu_rd0", 0, 5'd0, 1, 5'd1, 1, 5'd0, WB_MEM, 0, 32'd0, 0, 0);
        cyc("lu_re0", 0, 5'd5, 0, 5'd1, 1, 5'd5, WB_MEM, 0, 32'd0, 0, 0);
        cyc("not_load", 0, 5'd5, 1, 5'd1, 1, 5'd5, 3'd0, 0, 32'd0, 0, 0);
        cyc("lu_rs2", 0, 5'd2, 1, 5'd7, 1, 5'd7, WB_MEM, 0, 32'd0, 0, 0);
        // Branch and its flush window.
        cyc("branch", 0, 5'd0, 0, 5'd0, 0, 5'd0, 3'd0, 1, 32'h0000_0100, 0, 0);
        idle("br_n1");
        idle("br_n2");
        cyc("br_and_lu", 0, 5'd5, 1, 5'd1, 1, 5'd5, WB_MEM, 1, 32'h0000_0200, 0, 0);
        cyc("flush_lu_suppr", 0, 5'd5, 1, 5'd1, 1, 5'd5, WB_MEM, 0, 32'd0, 0, 0);
        idle("after_br_lu");
        // Memory stall interrupting the flush window.
        cyc("br_then_ms", 0, 5'd0, 0, 5'd0, 0, 5'd0, 3'd0, 1, 32'h0000_0300, 0, 0);
        mstall("ms_n1");
        mstall("ms_n2");
        mstall("ms_n3");
        idle("flush_resume");
        idle("ms_done");
        // Timeout after MEM_TIMEOUT-1 stalled cycles.
        for (int i = 0; i < 4; i++) mstall("timeout_seq");
        idle("post_timeout");
        idle("post_timeout2");
        // Reset in the middle of a memory wait.
        mstall("ms_pre_rst");
        mstall("ms_pre_rst");
        cyc("rst_mid_wait", 1, 5'd0, 0, 5'd0, 0, 5'd0, 3'd0, 0, 32'd0, 1, 0);
        mstall("quiet_after_rst");
        mstall("run_after_rst");
        idle("idle");

        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 99) == 0);
            if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 6);
            if (burst > 0) begin
                mreq = 1'b1; mrdy = 1'b0; burst--;
            end else begin
                mreq = ($urandom_range(0, 3) == 0);
                mrdy = 1'($urandom_range(0, 1));
            end
            br = (owed == 0) && ($urandom_range(0, 7) == 0);
            wb = ($urandom_range(0, 2) == 0) ? WB_MEM : 3'($urandom_range(0, 7));
            cyc("rand", r,
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), wb, br, $urandom, mreq, mrdy);
        end

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
